clk_tick_gen: RTL and testbench
===============================

# clk_tick_gen

Parametrised multi-channel clock divider and tick generator driven from the board clock `kartclk`. Each channel divides `kartclk` by its own run-time-loadable ratio and produces two outputs: a one-cycle `tick` strobe and a 50 % duty `ffclk` square wave. Typical uses are button-debounce sampling, mole timers and display refresh, all from one block. It adds synchronous reset, a global enable, synchronous restart and glitch-free divisor reload.

## Interface
- `NUM_CH`, default 4: number of independent channels (≥1).
- `CNT_W`, default 24: counter and divisor width in bits.
- `DEFAULT_DIV`, default 125000: reset value of every channel's divisor. Must be < 2^CNT_W.
- `SEL_W`, default max(1, clog2(NUM_CH)): width of `div_sel`.

- `kartclk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global count enable.
- `sync_clr`  in  1  synchronous restart of all channels.
- `div_we`  in  1  divisor write strobe.
- `div_sel`  in  SEL_W  channel index for the divisor write.
- `div_data`  in  CNT_W  new divisor value.
- `tick`  out  NUM_CH  per-channel one-cycle strobe, registered.
- `ffclk`  out  NUM_CH  per-channel square wave, registered.

## Operation
- Per-channel state:
  - `cnt` (CNT_W)
  - `div_act`: active divisor
  - `div_shd`: shadow divisor
  - `ffclk` bit
  - `tick` bit
- Reset (`rst`=1 at an edge):
  - `cnt`=0, `tick`=0, `ffclk`=0.
  - `div_act`=`div_shd`=DEFAULT_DIV.
  - `rst` has priority over all other inputs.
- Divisor write: when `div_we`=1 and `div_sel` < NUM_CH, `div_shd[div_sel]` ← `div_data`.
  - Writes with `div_sel` ≥ NUM_CH are ignored.
  - `div_act` is never written directly.
- Shadow transfer (`div_act` ← `div_shd`) happens only at:
  - a channel wrap;
  - a `sync_clr` edge;
  - every edge while `div_act`=0 (halted channel).
  - The transferred value is the shadow value before the edge, so a write landing on a wrap edge takes effect at the following wrap.
- Counting, per channel, when `rst`=0, `sync_clr`=0, `en`=1 and `div_act` ≥ 1:
  - if `cnt` == `div_act`−1: `cnt`←0, `tick`←1, `ffclk`←~`ffclk`, shadow transfer;
  - else `cnt`←`cnt`+1, `tick`←0.
- Divide-by-one: `div_act`=1 gives `tick`=1 every cycle and `ffclk` toggling every cycle.
- Halted channel (`div_act`=0): `cnt` held at 0, `tick`=0, `ffclk` holds its value.
- `en`=0: `cnt` and `ffclk` hold, `tick` forced 0. No shadow transfer except on halted channels.
- `sync_clr`=1 (priority below `rst`, above `en`):
  - all channels `cnt`=0, `tick`=0, `ffclk`=0;
  - shadow transfer on all channels.
- Channels are fully independent apart from the shared `en`, `sync_clr` and `rst`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With `div_act`=N and `en` held at 1 from edge 1 after reset release:
  - `tick` is high for exactly one cycle after every Nth enabled edge (edges N, 2N, …);
  - `tick` period is N cycles;
  - `ffclk` toggles at the same edges, giving period 2N and high time N.
- `en` low for k cycles stretches the current interval by exactly k cycles; no tick is lost or duplicated.
- Reload latency: a new divisor becomes active at the first wrap strictly after the write edge.
  - No interval ever uses a mix of old and new divisors.
- Halted restart: writing D≠0 to a halted channel gives `div_act`=D at the next edge; the first tick follows D enabled edges later.
- Shrinking the divisor: because transfer happens only at wrap, `cnt` < `div_act` always holds and there is no wrap-around overrun.
- Mid-operation `rst` or `sync_clr`: takes effect on the same edge; outputs are 0 the following cycle.

## Test plan
- DEFAULT_DIV=5, NUM_CH=2, `en`=1 after reset → `tick` high on cycles 5, 10, 15 for both channels; `ffclk` 0→1 at 5 and 1→0 at 10.
- Write div=3 to ch1 at cycle 7 → ch1 ticks at 10 (old ratio 5), then 13 and 16; ch0 unaffected.
- `en`=0 for cycles 3–5 with div=5 → first tick moves to cycle 8; `ffclk` frozen during the gap.
- Write div=0 to ch0, let it wrap → ch0 `tick` stays 0 and `ffclk` holds; then write 2 → ticks resume 2 cycles after activation.
- `sync_clr` pulse at cycle 7, then write 4 with `div_sel`=3 (out of range, NUM_CH=2) → counters restart and the next tick is at cycle 13; the invalid write is ignored.
- div=1 on a channel, then `rst` asserted mid-run → `tick` high every cycle and `ffclk` toggling every cycle; after `rst` all outputs 0 and the divisor is back to DEFAULT_DIV.

Source files
------------

// File: rtl/clk_tick_gen.sv
// clk_tick_gen
//   Multi-channel clock divider / tick generator running from kartclk.
//   Each channel divides kartclk by its own run-time divisor and produces a
//   one-cycle tick strobe plus a 50 % duty square wave (ffclk). Divisor
//   writes land in a shadow register and are moved into the active divisor
//   only at a wrap, a sync_clr, or on every edge while the channel is halted
//   (active divisor 0). An interval therefore never mixes two ratios.
//
// Ports
//   kartclk   in   system clock, rising edge
//   rst       in   synchronous active-high reset (highest priority)
//   en        in   global count enable
//   sync_clr  in   synchronous restart of all channels
//   div_we    in   divisor write strobe
//   div_sel   in   channel index for the write (out-of-range ignored)
//   div_data  in   new divisor value
//   tick      out  per-channel one-cycle strobe (registered)
//   ffclk     out  per-channel square wave (registered)
module clk_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 125000,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              kartclk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] ffclk
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Terminal count: last count of the current interval. A halted channel
  // (divisor 0) never reaches it.
  function automatic logic at_wrap(input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] d);
    return (d != '0) && (c == d - ONE);
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic             tick_q;
    logic             ff_q;
    logic             wr_hit;

    // div_sel values >= NUM_CH match no channel and are dropped.
    assign wr_hit = div_we && (div_sel == SEL_W'(g));

    always_ff @(posedge kartclk) begin
      if (rst) begin
        cnt     <= '0;
        div_act <= DIV_RST;
        div_shd <= DIV_RST;
        tick_q  <= 1'b0;
        ff_q    <= 1'b0;
      end else begin
        if (wr_hit) begin
          div_shd <= div_data;
        end
        // Transfers below read div_shd before this edge's write, so a write
        // coinciding with a wrap only takes effect at the following wrap.
        if (sync_clr) begin
          cnt     <= '0;
          tick_q  <= 1'b0;
          ff_q    <= 1'b0;
          div_act <= div_shd;
        end else if (div_act == '0) begin
          // Halted: keep polling the shadow, independent of en.
          cnt     <= '0;
          tick_q  <= 1'b0;
          div_act <= div_shd;
        end else if (en) begin
          if (at_wrap(cnt, div_act)) begin
            cnt     <= '0;
            tick_q  <= 1'b1;
            ff_q    <= ~ff_q;
            div_act <= div_shd;
          end else begin
            cnt     <= cnt + ONE;
            tick_q  <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[g]  = tick_q;
    assign ffclk[g] = ff_q;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
module tb_clk_tick_gen;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 5;
  localparam int SEL_W       = 2;

  logic              kartclk = 1'b0;
  logic              rst;
  logic              en;
  logic              sync_clr;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] ffclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 kartclk = ~kartclk;

  clk_tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .SEL_W       (SEL_W)
  ) dut (
    .kartclk  (kartclk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_we   (div_we),
    .div_sel  (div_sel),
    .div_data (div_data),
    .tick     (tick),
    .ffclk    (ffclk)
  );

  // Advance to edge n (counted from reset release) and settle 1 time unit.
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge kartclk);
      cyc++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    sync_clr = 1'b0;
    div_we   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    @(posedge kartclk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    cyc = 0;
  endtask

  // Divisor write sampled at edge n.
  task automatic wr_at(input int n, input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data);
    div_sel  = sel;
    div_data = data;
    div_we   = 1'b1;
    run_to(n);
    div_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_tick", tick, 2'b00);
    chk("rst_ffclk", ffclk, 2'b00);

    // Default divide-by-5, then ch1 reload to 3 written at edge 7
    run_to(4);  chk("a_t4", tick, 2'b00);
    run_to(5);  chk("a_t5", tick, 2'b11);  chk("a_f5", ffclk, 2'b11);
    run_to(6);  chk("a_t6", tick, 2'b00);
    wr_at(7, 2'd1, 8'd3);
    run_to(10); chk("a_t10", tick, 2'b11); chk("a_f10", ffclk, 2'b00);
    run_to(12); chk("a_t12", tick, 2'b00);
    run_to(13); chk("a_t13", tick, 2'b10); chk("a_f13", ffclk, 2'b10);
    run_to(15); chk("a_t15", tick, 2'b01); chk("a_f15", ffclk, 2'b11);
    run_to(16); chk("a_t16", tick, 2'b10); chk("a_f16", ffclk, 2'b01);

    // Enable gaps stretch the interval
    do_reset();
    run_to(2);
    en = 1'b0;
    run_to(5);  chk("b_t5", tick, 2'b00);  chk("b_f5", ffclk, 2'b00);
    en = 1'b1;
    run_to(7);  chk("b_t7", tick, 2'b00);
    run_to(8);  chk("b_t8", tick, 2'b11);  chk("b_f8", ffclk, 2'b11);
    run_to(9);  chk("b_t9", tick, 2'b00);
    en = 1'b0;
    run_to(11); chk("b_t11", tick, 2'b00); chk("b_f11", ffclk, 2'b11);
    en = 1'b1;
    run_to(14); chk("b_t14", tick, 2'b00);
    run_to(15); chk("b_t15", tick, 2'b11); chk("b_f15", ffclk, 2'b00);

    // Halt ch0 with divisor 0, then restart it with 2
    do_reset();
    wr_at(1, 2'd0, 8'd0);
    run_to(5);  chk("c_t5", tick, 2'b11);  chk("c_f5", ffclk, 2'b11);
    run_to(8);  chk("c_t8", tick, 2'b00);  chk("c_f8", ffclk, 2'b11);
    run_to(10); chk("c_t10", tick, 2'b10); chk("c_f10", ffclk, 2'b01);
    wr_at(11, 2'd0, 8'd2);
    run_to(13); chk("c_t13", tick, 2'b00);
    run_to(14); chk("c_t14", tick, 2'b01); chk("c_f14", ffclk, 2'b00);
    run_to(15); chk("c_t15", tick, 2'b10); chk("c_f15", ffclk, 2'b10);
    run_to(16); chk("c_t16", tick, 2'b01); chk("c_f16", ffclk, 2'b11);

    // sync_clr restart, then out-of-range write ignored
    do_reset();
    run_to(7);
    sync_clr = 1'b1;
    run_to(8);
    sync_clr = 1'b0;
    chk("d_t8", tick, 2'b00);  chk("d_f8", ffclk, 2'b00);
    wr_at(9, 2'd3, 8'd4);
    run_to(12); chk("d_t12", tick, 2'b00);
    run_to(13); chk("d_t13", tick, 2'b11); chk("d_f13", ffclk, 2'b11);
    run_to(17); chk("d_t17", tick, 2'b00);
    run_to(18); chk("d_t18", tick, 2'b11); chk("d_f18", ffclk, 2'b00);

    // Divide-by-one on ch1, en low for one edge, then rst mid-run
    do_reset();
    wr_at(1, 2'd1, 8'd1);
    run_to(5);  chk("e_t5", tick, 2'b11);
    run_to(6);  chk("e_t6", tick, 2'b10);  chk("e_f6", ffclk, 2'b01);
    run_to(7);  chk("e_t7", tick, 2'b10);  chk("e_f7", ffclk, 2'b11);
    en = 1'b0;
    run_to(8);  chk("e_t8", tick, 2'b00);  chk("e_f8", ffclk, 2'b11);
    en  = 1'b1;
    rst = 1'b1;
    run_to(9);  chk("e_t9", tick, 2'b00);  chk("e_f9", ffclk, 2'b00);
    rst = 1'b0;
    cyc = 0;
    run_to(4);  chk("e_r4", tick, 2'b00);
    run_to(5);  chk("e_r5", tick, 2'b11);  chk("e_rf5", ffclk, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
